// File: rtl/posit_defines.sv
// rtl/posit_defines.sv - shared posit<4,0> constants and the unrounded-result record
package posit_defines;

   localparam logic [3:0] POSIT4_NAR    = 4'b1000;
   localparam logic [3:0] POSIT4_ZERO   = 4'b0000;
   localparam logic [3:0] POSIT4_MAXPOS = 4'b0111;
   localparam logic [3:0] POSIT4_MINPOS = 4'b0001;

   // Magnitude pattern plus round bits, carried from stage 1 to stage 2
   typedef struct packed {
      logic [2:0] m;
      logic       lsb;
      logic       guard;
      logic       sticky;
      logic       sat;
      logic       sign;
      logic       zero;
      logic       nar;
   } posit4_unrounded_t;

endpackage

// File: rtl/posit_round_4_0.sv
// rtl/posit_round_4_0.sv - round-to-nearest-even, negate and special-case selection
module posit_round_4_0
   import posit_defines::*;
(
   input  logic [2:0] m,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   input  logic       sat,
   input  logic       sign,
   input  logic       zero,
   input  logic       nar,
   output logic [3:0] posit,
   output logic       inexact
);

   logic       up;
   logic [2:0] mag;
   logic [3:0] pos_word;

   always_comb begin
      up       = guard & (lsb | sticky);
      // Stage-1 rows guarantee m + up never carries out of 3 bits
      mag      = m + {2'b00, up};
      pos_word = {1'b0, mag};
      posit    = pos_word;
      inexact  = guard | sticky | sat;
      if (sign) begin
         posit = ~pos_word + 4'd1;
      end
      if (nar) begin
         posit   = POSIT4_NAR;
         inexact = 1'b0;
      end else if (zero) begin
         posit   = POSIT4_ZERO;
         inexact = 1'b0;
      end
   end

endmodule

// File: rtl/posit_encode_4_0.sv
// rtl/posit_encode_4_0.sv - two-stage valid/ready posit<4,0> encoder with rounding
module posit_encode_4_0
   import posit_defines::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        fraction_i,
   input  logic signed [3:0] scale_i,
   input  logic              sign_i,
   input  logic              zero_i,
   input  logic              NaR_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [3:0]        posit_o,
   output logic              inexact_o
);

   posit4_unrounded_t s1_next;
   posit4_unrounded_t s1_q;
   logic              s1_valid;
   logic              s2_advance;
   logic [3:0]        rnd_posit;
   logic              rnd_inexact;

   assign s2_advance = !valid_o | ready_i;
   assign ready_o    = !s1_valid | s2_advance;

   // Map the signed scale onto regime/fraction bit positions of a 4-bit posit
   always_comb begin
      s1_next      = '0;
      s1_next.sign = sign_i;
      s1_next.zero = zero_i;
      s1_next.nar  = NaR_i;
      if (scale_i <= -4'sd3) begin
         s1_next.m   = POSIT4_MINPOS[2:0];
         s1_next.sat = 1'b1;
      end else if (scale_i == -4'sd2) begin
         s1_next.m      = 3'b001;
         s1_next.lsb    = 1'b1;
         s1_next.guard  = fraction_i[3];
         s1_next.sticky = |fraction_i[2:0];
      end else if (scale_i == -4'sd1) begin
         s1_next.m      = {2'b01, fraction_i[3]};
         s1_next.lsb    = fraction_i[3];
         s1_next.guard  = fraction_i[2];
         s1_next.sticky = |fraction_i[1:0];
      end else if (scale_i == 4'sd0) begin
         s1_next.m      = {2'b10, fraction_i[3]};
         s1_next.lsb    = fraction_i[3];
         s1_next.guard  = fraction_i[2];
         s1_next.sticky = |fraction_i[1:0];
      end else if (scale_i == 4'sd1) begin
         s1_next.m      = 3'b110;
         s1_next.guard  = fraction_i[3];
         s1_next.sticky = |fraction_i[2:0];
      end else begin
         s1_next.m   = POSIT4_MAXPOS[2:0];
         s1_next.sat = (scale_i > 4'sd2) | (|fraction_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (ready_o) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_q <= s1_next;
         end
      end
   end

   posit_round_4_0 u_round (
      .m       (s1_q.m),
      .lsb     (s1_q.lsb),
      .guard   (s1_q.guard),
      .sticky  (s1_q.sticky),
      .sat     (s1_q.sat),
      .sign    (s1_q.sign),
      .zero    (s1_q.zero),
      .nar     (s1_q.nar),
      .posit   (rnd_posit),
      .inexact (rnd_inexact)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o   <= 1'b0;
         posit_o   <= POSIT4_ZERO;
         inexact_o <= 1'b0;
      end else if (s2_advance) begin
         valid_o <= s1_valid;
         if (s1_valid) begin
            posit_o   <= rnd_posit;
            inexact_o <= rnd_inexact;
         end
      end
   end

endmodule

// File: tb/tb_posit_encode_4_0.sv
// tb/tb_posit_encode_4_0.sv - scoreboard bench for the posit<4,0> encoder
module tb_posit_encode_4_0;

   logic              clk;
   logic              rst;
   logic              valid_i;
   logic              ready_o;
   logic [3:0]        fraction_i;
   logic signed [3:0] scale_i;
   logic              sign_i;
   logic              zero_i;
   logic              NaR_i;
   logic              valid_o;
   logic              ready_i;
   logic [3:0]        posit_o;
   logic              inexact_o;

   typedef struct {
      logic [3:0] posit;
      logic       inexact;
      int         cyc;
      bit         chk_lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests;
   int   n_fail;
   int   cyc;
   bit   held_valid;
   logic [3:0] held_posit;
   logic       held_inexact;
   int   seen_after_rst;

   posit_encode_4_0 dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .fraction_i (fraction_i),
      .scale_i    (scale_i),
      .sign_i     (sign_i),
      .zero_i     (zero_i),
      .NaR_i      (NaR_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .posit_o    (posit_o),
      .inexact_o  (inexact_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: compares each beat leaving the DUT against the scoreboard head
   always @(negedge clk) begin
      if (rst) begin
         held_valid = 1'b0;
      end else begin
         if (valid_o) seen_after_rst++;
         if (valid_o && held_valid) begin
            check("hold_posit", posit_o, held_posit);
            check("hold_inexact", inexact_o, held_inexact);
         end
         if (valid_o && !ready_i) begin
            held_valid   = 1'b1;
            held_posit   = posit_o;
            held_inexact = inexact_o;
         end else begin
            held_valid = 1'b0;
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("posit", posit_o, e.posit);
               check("inexact", inexact_o, e.inexact);
               if (e.chk_lat) check("latency", cyc - e.cyc, 2);
            end
         end
      end
   end

   task automatic send(input bit sg, input int sc, input logic [3:0] f, input bit z, input bit n,
                       input logic [3:0] ep, input bit ei, input bit lat);
      bit done;
      done       = 1'b0;
      sign_i     = sg;
      scale_i    = 4'(sc);
      fraction_i = f;
      zero_i     = z;
      NaR_i      = n;
      valid_i    = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (ready_o) begin
            exp_t e;
            e.posit   = ep;
            e.inexact = ei;
            e.cyc     = cyc;
            e.chk_lat = lat;
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #2;
      end
      if (!done) check("accept_timeout", 0, 1);
      valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #2;
      check("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; held_valid = 0; seen_after_rst = 0;
      rst = 1'b1; valid_i = 0; ready_i = 1; fraction_i = 0; scale_i = 0;
      sign_i = 0; zero_i = 0; NaR_i = 0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid_o", valid_o, 0);
      check("rst_posit_o", posit_o, 0);
      check("rst_inexact_o", inexact_o, 0);
      rst = 1'b0;
      #1;
      check("rst_ready_o", ready_o, 1);
      @(posedge clk); #2;

      // Exact encodings
      send(0, 0, 4'b0000, 0, 0, 4'b0100, 0, 1);
      send(0, 0, 4'b1000, 0, 0, 4'b0101, 0, 1);
      send(0, 1, 4'b0000, 0, 0, 4'b0110, 0, 1);
      send(0, -2, 4'b0000, 0, 0, 4'b0001, 0, 1);
      send(0, 2, 4'b0000, 0, 0, 4'b0111, 0, 1);
      // Ties and rounding
      send(0, -1, 4'b0100, 0, 0, 4'b0010, 1, 1);
      send(0, -1, 4'b1100, 0, 0, 4'b0100, 1, 1);
      send(0, 0, 4'b1100, 0, 0, 4'b0110, 1, 1);
      send(0, 1, 4'b1001, 0, 0, 4'b0111, 1, 1);
      send(0, -2, 4'b1000, 0, 0, 4'b0010, 1, 1);
      // Saturation and sign
      send(0, 5, 4'b0000, 0, 0, 4'b0111, 1, 1);
      send(0, -8, 4'b0000, 0, 0, 4'b0001, 1, 1);
      send(0, 2, 4'b0001, 0, 0, 4'b0111, 1, 1);
      send(1, 0, 4'b1000, 0, 0, 4'b1011, 0, 1);
      send(1, 2, 4'b0000, 0, 0, 4'b1001, 0, 1);
      // Specials
      send(0, 0, 4'b0000, 1, 1, 4'b1000, 0, 1);
      send(1, 3, 4'b1010, 1, 0, 4'b0000, 0, 1);
      drain();

      // Backpressure: two beats fill the pipe, third must stall
      ready_i = 1'b0;
      send(0, 0, 4'b0000, 0, 0, 4'b0100, 0, 0);
      send(0, 1, 4'b0000, 0, 0, 4'b0110, 0, 0);
      #1;
      check("bp_ready_low", ready_o, 0);
      fork
         send(0, -1, 4'b1000, 0, 0, 4'b0011, 0, 0);
         begin
            repeat (4) @(posedge clk);
            #2 ready_i = 1'b1;
         end
      join
      drain();

      // Async reset with two beats in flight
      send(0, 0, 4'b0000, 0, 0, 4'b0100, 0, 0);
      send(0, 1, 4'b0000, 0, 0, 4'b0110, 0, 0);
      #1 rst = 1'b1;
      #1;
      check("rst_async_valid_o", valid_o, 0);
      exp_q.delete();
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      seen_after_rst = 0;
      repeat (6) @(posedge clk);
      #2;
      check("no_beat_after_rst", seen_after_rst, 0);
      check("ready_after_rst", ready_o, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/posit_encode_4_0.md
Name: posit_encode_4_0

Overview:
- Return-path encoder for posit<4,0> arithmetic. Takes a decoded, unrounded result (sign, scale, 4-bit fraction, zero, NaR), for example from the posit<4,0> multiplier.
- Rounds the result to nearest, ties to even, on the posit bit string, and packs it into a 4-bit posit word.
- 2-stage valid/ready pipeline with full backpressure. Sits between the arithmetic cores and the result writeback or stream.

Parameters:
- None. Format is fixed to posit<4,0>. Widths come from posit_defines.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  encoder can accept a beat
- fraction_i  in  4  fraction bits below the hidden 1; bit 3 has weight 2^-1, bit 0 has weight 2^-4
- scale_i  in  4 (signed)  unbiased exponent, range -8..7
- sign_i  in  1  result sign
- zero_i  in  1  exact zero
- NaR_i  in  1  not-a-real
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts
- posit_o  out  4  encoded posit<4,0>
- inexact_o  out  1  rounding discarded nonzero bits, or the value saturated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: valid_o=0, posit_o=4'b0000, inexact_o=0, and both stage valid flags are 0. ready_o=1 once rst deasserts.
- Reset mid-operation: any in-flight beats are dropped with no output.
- Handshake: a transfer occurs on a cycle where valid and ready are both 1.
  - ready_o = !s1_valid | s2_advance, where s2_advance = !s2_valid | ready_i.
  - A stage loads when it is empty or its contents are leaving that cycle.
  - No combinational path from valid_i to valid_o.
  - posit_o and inexact_o hold stable while valid_o=1 and ready_i=0.
- Latency and throughput: 2 cycles from accept to valid_o. Throughput is 1 beat per cycle when ready_i stays high.
- Stage 1 registers a magnitude pattern m[2:0] plus the lsb, guard and sticky bits, computed from scale_i and fraction_i (f = fraction_i):
  - scale <= -3: m=001, no round-up, inexact=1 (saturates to minpos; posits never round to 0).
  - scale = -2: m=001, lsb=1, guard=f[3], sticky=|f[2:0].
  - scale = -1: m={01,f[3]}, lsb=f[3], guard=f[2], sticky=|f[1:0].
  - scale = 0: m={10,f[3]}, lsb=f[3], guard=f[2], sticky=|f[1:0].
  - scale = 1: m=110, lsb=0, guard=f[3], sticky=|f[2:0].
  - scale >= 2: m=111, no round-up. inexact=(scale>2)|(f!=0), saturating to maxpos. Rounding never produces NaR.
- Stage 2 rounding and sign:
  - up = guard & (lsb | sticky); mag = m + up. mag cannot exceed 111 given the rows above.
  - inexact_o = guard | sticky | saturation flag.
  - posit_o = sign ? (~{0,mag} + 1) : {0,mag}.
- Special cases, with priority NaR > zero > normal:
  - NaR_i: posit_o=1000, inexact_o=0.
  - zero_i: posit_o=0000, inexact_o=0. The sign is ignored.
- Scale arithmetic is signed. Compare scale_i using a signed interpretation; -8 must map to minpos.

Decomposition:
- posit_defines gains:
  - constants POSIT4_NAR=4'b1000, POSIT4_ZERO=4'b0000, POSIT4_MAXPOS=4'b0111, POSIT4_MINPOS=4'b0001
  - struct typedef posit4_unrounded_t {m[2:0], lsb, guard, sticky, sat, sign, zero, NaR}
- One combinational sub-module, posit_round_4_0, implements the stage-2 round-and-negate step. posit_encode_4_0 owns the pipeline registers and the handshake.

Test Plan:
- Exact encodings, positive sign:
  - scale=0, f=0000 -> 0100
  - scale=0, f=1000 -> 0101
  - scale=1, f=0000 -> 0110
  - scale=-2, f=0000 -> 0001
  - All with inexact_o=0 and valid_o exactly 2 cycles after accept.
- Tie and round cases:
  - scale=-1, f=0100 -> 0010 (tie, even stays)
  - scale=-1, f=1100 -> 0100 (tie, odd rounds up across regime)
  - scale=0, f=1100 -> 0110
  - scale=1, f=1001 -> 0111
  - All with inexact_o=1.
- Saturation and sign:
  - scale=5 -> 0111, inexact_o=1
  - scale=-8 -> 0001, inexact_o=1
  - sign=1, scale=0, f=1000 -> 1011
  - sign=1, scale=2 -> 1001
- Specials:
  - NaR=1 with zero=1 -> 1000
  - zero=1, sign=1 -> 0000
  - Both with inexact_o=0.
- Backpressure:
  - Hold ready_i=0 while streaming 3 beats: ready_o drops after 2 accepted, and posit_o stays stable.
  - Release ready_i: beats exit in order, 1 per cycle, none lost or duplicated.
- Async reset:
  - Assert rst between clock edges with 2 beats in flight: valid_o falls immediately, and no beat emerges after release.
